reservation_station: RTL

Single-entry reservation station; consumer end of the modified-issue and modified-commit buses driven by the operand-modifier stage. Captures an issued instruction addressed to its station ID and snoops the commit bus for still-pending source operands. When both operands are valid it hands them to an attached functional unit, then arbitrates for the commit bus and broadcasts the result tagged with its own ID. That broadcast is the packet the operand-modifier queues match on.

---
 rtl/reservation_station.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// reservation_station: single-entry reservation station.
// Captures an issue packet addressed to RS_ID, snoops the commit bus for
// pending source operands, hands both operands to an attached functional
// unit, then requests the commit bus and broadcasts the result tagged RS_ID.
//
// Build option: define RS_WATCHDOG_EN to add a WAIT_OPS watchdog that sets
// a sticky oTimeout after WATCHDOG_CYCLES cycles spent waiting on operands.
// Without it oTimeout is tied low.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | entry free, accepting an issue addressed to RS_ID
// WAIT_OPS | entry held, at least one source still waiting on a broadcast
// EXECUTE  | both operands valid, presented to the functional unit
// COMMIT   | result held, requesting the commit bus until granted
module reservation_station #(
  parameter logic [3:0]  RS_ID           = 4'd1,
  parameter int          WIDTH           = 32,
  parameter logic [15:0] WATCHDOG_CYCLES = 16'd255
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [3:0]         iIssueRsID,
  input  logic [3:0]         iIssueSrc0Rs,
  input  logic [3:0]         iIssueSrc1Rs,
  input  logic [3*WIDTH-1:0] iIssueSrc0Data,
  input  logic [3*WIDTH-1:0] iIssueSrc1Data,
  input  logic [7:0]         iIssueDst,
  input  logic [2:0]         iIssueWe,
  input  logic [3:0]         iCommitRsID,
  input  logic [3*WIDTH-1:0] iCommitData,
  output logic               oBusy,
  output logic               oIssueCollision,
  output logic               oExeValid,
  output logic [3*WIDTH-1:0] oExeA,
  output logic [3*WIDTH-1:0] oExeB,
  input  logic               iExeDone,
  input  logic [3*WIDTH-1:0] iExeResult,
  output logic               oCommitRequest,
  input  logic               iCommitGrant,
  output logic [3:0]         oCommitRsID,
  output logic [7:0]         oCommitDst,
  output logic [2:0]         oCommitWe,
  output logic [3*WIDTH-1:0] oCommitData,
  output logic               oTimeout
);

  localparam int DW = 3 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_OPS = 2'd1,
    S_EXECUTE  = 2'd2,
    S_COMMIT   = 2'd3
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_src0;
  logic [DW-1:0]   r_src1;
  logic [3:0]      r_rs0;
  logic [3:0]      r_rs1;
  logic [7:0]      r_dst;
  logic [2:0]      r_we;
  logic [DW-1:0]   r_result;
  logic            r_collision;

  logic            w_issue_hit;
  logic            w_fwd0;
  logic            w_fwd1;
  logic            w_ready0;
  logic            w_ready1;
  logic            w_snoop0;
  logic            w_snoop1;
  logic            w_enter_wait;

  // Our own ID is never a legal producer, so a self-dependency stays pending.
  assign w_issue_hit  = (iIssueRsID == RS_ID);
  assign w_fwd0       = (iIssueSrc0Rs != 4'd0) && (iIssueSrc0Rs != RS_ID) &&
                        (iIssueSrc0Rs == iCommitRsID);
  assign w_fwd1       = (iIssueSrc1Rs != 4'd0) && (iIssueSrc1Rs != RS_ID) &&
                        (iIssueSrc1Rs == iCommitRsID);
  assign w_ready0     = (iIssueSrc0Rs == 4'd0) || w_fwd0;
  assign w_ready1     = (iIssueSrc1Rs == 4'd0) || w_fwd1;
  assign w_snoop0     = (r_rs0 != 4'd0) && (r_rs0 != RS_ID) && (r_rs0 == iCommitRsID);
  assign w_snoop1     = (r_rs1 != 4'd0) && (r_rs1 != RS_ID) && (r_rs1 == iCommitRsID);
  assign w_enter_wait = (r_state == S_IDLE) && w_issue_hit && !(w_ready0 && w_ready1);

  // Main sequencing FSM: issue capture, operand snooping, execute and commit.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_src0      <= '0;
      r_src1      <= '0;
      r_rs0       <= '0;
      r_rs1       <= '0;
      r_dst       <= '0;
      r_we        <= '0;
      r_result    <= '0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_issue_hit && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_issue_hit) begin
            r_dst  <= iIssueDst;
            r_we   <= iIssueWe;
            r_src0 <= w_fwd0 ? iCommitData : iIssueSrc0Data;
            r_src1 <= w_fwd1 ? iCommitData : iIssueSrc1Data;
            r_rs0  <= w_ready0 ? 4'd0 : iIssueSrc0Rs;
            r_rs1  <= w_ready1 ? 4'd0 : iIssueSrc1Rs;
            r_state <= (w_ready0 && w_ready1) ? S_EXECUTE : S_WAIT_OPS;
          end
        end
        S_WAIT_OPS: begin
          // Exit one cycle after the last pending flag has cleared.
          if ((r_rs0 == 4'd0) && (r_rs1 == 4'd0)) begin
            r_state <= S_EXECUTE;
          end
          if (w_snoop0) begin
            r_src0 <= iCommitData;
            r_rs0  <= 4'd0;
          end
          if (w_snoop1) begin
            r_src1 <= iCommitData;
            r_rs1  <= 4'd0;
          end
        end
        S_EXECUTE: begin
          if (iExeDone) begin
            r_result <= iExeResult;
            r_state  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (iCommitGrant) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RS_WATCHDOG_EN
  logic [15:0] r_wdog;
  logic        r_timeout;
  logic [15:0] w_wdog_next;

  assign w_wdog_next = (r_wdog == 16'hFFFF) ? r_wdog : (r_wdog + 16'd1);

  // Saturating WAIT_OPS cycle counter with a sticky timeout flag.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wdog    <= 16'd0;
      r_timeout <= 1'b0;
    end else if (w_enter_wait) begin
      r_wdog <= 16'd0;
    end else if (r_state == S_WAIT_OPS) begin
      r_wdog <= w_wdog_next;
      if (w_wdog_next >= WATCHDOG_CYCLES) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign oTimeout = r_timeout;
`else
  logic [16:0] w_unused_wdog;
  assign w_unused_wdog = {w_enter_wait, WATCHDOG_CYCLES};
  assign oTimeout      = 1'b0;
`endif

  assign oBusy           = (r_state != S_IDLE);
  assign oIssueCollision = r_collision;
  assign oExeValid       = (r_state == S_EXECUTE);
  assign oExeA           = r_src0;
  assign oExeB           = r_src1;
  assign oCommitRequest  = (r_state == S_COMMIT);
  assign oCommitRsID     = (r_state == S_COMMIT) ? RS_ID : 4'd0;
  assign oCommitDst      = r_dst;
  assign oCommitWe       = r_we;
  assign oCommitData     = r_result;

endmodule
